// File: rtl/i2c_slave_target.sv
// I2C target: 2-flop synchronised scl/sda, START/STOP detection, 7-bit address match,
// write bytes to rx_data/rx_valid, read bytes from tx_data via tx_load; open-drain sda_oe.
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h4C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       rw_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_IGNORE, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic        r_sda_oe, w_sda_oe_nxt;
  logic [7:0]  r_rx_data, w_rx_data_nxt;
  logic        r_rx_valid, w_rx_valid_nxt;
  logic        r_tx_load, w_tx_load_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_rw_out, w_rw_out_nxt;
  logic        w_load;

  logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;
  logic [7:0] w_shift_in;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_sda_rise = r_sda_s2 & ~r_sda_d;
  assign w_sda_fall = ~r_sda_s2 & r_sda_d;
  // scl must be high in both the current and previous sample for a bus condition
  assign w_start    = w_sda_fall & r_scl_s2 & r_scl_d;
  assign w_stop     = w_sda_rise & r_scl_s2 & r_scl_d;
  assign w_shift_in = {r_shift[6:0], r_sda_s2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      r_busy     <= 1'b0;
      r_rw_out   <= 1'b0;
    end else begin
      r_scl_s1   <= scl_in;
      r_scl_s2   <= r_scl_s1;
      r_scl_d    <= r_scl_s2;
      r_sda_s1   <= sda_in;
      r_sda_s2   <= r_sda_s1;
      r_sda_d    <= r_sda_s2;
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_load  <= w_tx_load_nxt;
      r_busy     <= w_busy_nxt;
      r_rw_out   <= w_rw_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_load_nxt  = 1'b0;
    w_busy_nxt     = r_busy;
    w_rw_out_nxt   = r_rw_out;
    w_load         = 1'b0;

    if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = '0;
      w_shift_nxt   = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_IGNORE: ;
        S_ADDR: if (w_scl_rise) begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_bit_cnt_nxt = '0;
            if (w_shift_in[7:1] == SLAVE_ADDR) begin
              w_rw_out_nxt = w_shift_in[0];
              w_busy_nxt   = 1'b1;
              w_state_nxt  = S_ADDR_ACK;
            end else begin
              w_state_nxt  = S_IGNORE;
            end
          end
        end
        // bit_cnt 0: waiting for the falling edge that starts the ACK slot; 1: ACK held
        S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd0) begin
            w_sda_oe_nxt  = 1'b1;
            w_bit_cnt_nxt = 4'd1;
          end else if (r_state == S_WR_ACK || !r_rw_out) begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_WR_DATA;
          end else begin
            w_load = 1'b1;
          end
        end
        S_WR_DATA: if (w_scl_rise) begin
          w_shift_nxt   = w_shift_in;
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_rx_data_nxt  = w_shift_in;
            w_rx_valid_nxt = 1'b1;
            w_bit_cnt_nxt  = '0;
            w_state_nxt    = S_WR_ACK;
          end
        end
        S_RD_DATA: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_RD_ACK;
          end else begin
            w_sda_oe_nxt  = ~r_shift[6];
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!r_sda_s2) w_bit_cnt_nxt = 4'd1;
            else           w_state_nxt   = S_IGNORE;
          end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
            w_load = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    if (w_load) begin
      w_tx_load_nxt = 1'b1;
      w_shift_nxt   = tx_data;
      w_sda_oe_nxt  = ~tx_data[7];
      w_bit_cnt_nxt = 4'd1;
      w_state_nxt   = S_RD_DATA;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_load  = r_tx_load;
  assign busy     = r_busy;
  assign rw_out   = r_rw_out;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-banged I2C master on a wired-AND sda, scoreboard
// queues for written bytes (checked on rx_valid) and read bytes (checked on the bus).
module tb_i2c_slave_target;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_in_w;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;
  logic       rw_out;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txload = 0;
  int   txl0;
  logic oe_seen = 1'b0;
  logic prev_oe = 1'b0;
  logic ack_s;
  logic dummy;
  logic [7:0] rd_b;
  logic [7:0] q_rx[$];
  logic [7:0] q_rd[$];

  assign sda_in_w = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_target #(.SLAVE_ADDR(7'h4C)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_in_w), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .busy(busy), .rw_out(rw_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: sda_oe may only move while scl is low (or under reset); written bytes vs queue.
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (sda_oe !== prev_oe) chk("oe_change_scl_low", 32'(scl & rst), 32'd0);
    prev_oe = sda_oe;
    if (rx_valid === 1'b1) begin
      chk("rx_expected", 32'(q_rx.size() != 0), 32'd1);
      if (q_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(q_rx.pop_front()));
    end
    if (tx_load === 1'b1) n_txload++;
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl) begin
      sda_m = 1'b1; wt(T); scl = 1'b1; wt(T);
    end
    sda_m = 1'b0; wt(T); scl = 1'b0; wt(T);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wt(T); scl = 1'b1; wt(T); sda_m = 1'b1; wt(2 * T);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; wt(T); scl = 1'b1; wt(T); s = sda_in_w; wt(T); scl = 1'b0; wt(T);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
  endtask

  initial begin
    wt(4);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_load", 32'(tx_load), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rw_out", 32'(rw_out), 32'd0);
    rst = 1'b1;
    wt(4);

    // 1: write 0xA5
    q_rx.push_back(8'hA5);
    bus_start();
    send_byte(8'h98, ack_s);
    chk("t1_addr_ack", 32'(ack_s), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rw_out", 32'(rw_out), 32'd0);
    send_byte(8'hA5, ack_s);
    chk("t1_data_ack", 32'(ack_s), 32'd0);
    bus_stop();
    chk("t1_busy_stop", 32'(busy), 32'd0);
    chk("t1_rx_drained", 32'(q_rx.size()), 32'd0);

    // 2: read 0x3C (master ACK) then 0xF0 (master NACK)
    txl0 = n_txload;
    tx_data = 8'h3C;
    q_rd.push_back(8'h3C);
    bus_start();
    send_byte(8'h99, ack_s);
    chk("t2_addr_ack", 32'(ack_s), 32'd0);
    chk("t2_rw_out", 32'(rw_out), 32'd1);
    read_byte(rd_b);
    chk("t2_byte0", 32'(rd_b), 32'(q_rd.pop_front()));
    tx_data = 8'hF0;
    q_rd.push_back(8'hF0);
    bus_bit(1'b0, dummy);
    read_byte(rd_b);
    chk("t2_byte1", 32'(rd_b), 32'(q_rd.pop_front()));
    bus_bit(1'b1, dummy);
    chk("t2_busy_after_nack", 32'(busy), 32'd1);
    bus_stop();
    chk("t2_tx_loads", 32'(n_txload - txl0), 32'd2);
    chk("t2_busy_stop", 32'(busy), 32'd0);

    // 3: address miss
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h9A, ack_s);
    chk("t3_addr_nack", 32'(ack_s), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    send_byte(8'h55, ack_s);
    chk("t3_data_nack", 32'(ack_s), 32'd1);
    bus_stop();
    chk("t3_oe_never", 32'(oe_seen), 32'd0);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // 4: write 0x11, repeated START, read one byte
    txl0 = n_txload;
    q_rx.push_back(8'h11);
    bus_start();
    send_byte(8'h98, ack_s);
    chk("t4_addr_ack", 32'(ack_s), 32'd0);
    chk("t4_rw_w", 32'(rw_out), 32'd0);
    send_byte(8'h11, ack_s);
    chk("t4_rx_drained", 32'(q_rx.size()), 32'd0);
    tx_data = 8'h5A;
    q_rd.push_back(8'h5A);
    bus_start();
    chk("t4_busy_sr", 32'(busy), 32'd0);
    send_byte(8'h99, ack_s);
    chk("t4_addr2_ack", 32'(ack_s), 32'd0);
    chk("t4_rw_r", 32'(rw_out), 32'd1);
    read_byte(rd_b);
    chk("t4_rd_byte", 32'(rd_b), 32'(q_rd.pop_front()));
    bus_bit(1'b1, dummy);
    bus_stop();
    chk("t4_tx_loads", 32'(n_txload - txl0), 32'd1);
    chk("t4_rx_data", 32'(rx_data), 32'h11);

    // 5: STOP after 4 bits, then a normal write
    bus_start();
    send_byte(8'h98, ack_s);
    for (int i = 0; i < 4; i++) bus_bit(i[0], dummy);
    bus_stop();
    chk("t5_busy_idle", 32'(busy), 32'd0);
    q_rx.push_back(8'hC3);
    bus_start();
    send_byte(8'h98, ack_s);
    chk("t5_addr_ack", 32'(ack_s), 32'd0);
    send_byte(8'hC3, ack_s);
    chk("t5_data_ack", 32'(ack_s), 32'd0);
    bus_stop();
    chk("t5_rx_drained", 32'(q_rx.size()), 32'd0);

    // 6: reset while the target drives a 0 read bit
    tx_data = 8'h3C;
    bus_start();
    send_byte(8'h99, ack_s);
    chk("t6_drive0", 32'(sda_oe), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_rw_out", 32'(rw_out), 32'd0);
    chk("t6_rst_rx_data", 32'(rx_data), 32'd0);
    chk("t6_rst_tx_load", 32'(tx_load), 32'd0);
    wt(3);
    rst = 1'b1;
    sda_m = 1'b1; wt(T); scl = 1'b1; wt(2 * T);
    q_rx.push_back(8'h77);
    bus_start();
    send_byte(8'h98, ack_s);
    chk("t6_resume_ack", 32'(ack_s), 32'd0);
    send_byte(8'h77, ack_s);
    bus_stop();
    chk("t6_rx_drained", 32'(q_rx.size()), 32'd0);
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("end_rd_drained", 32'(q_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
